// File: rtl/cl_ctrl_pkg.sv
// cl_ctrl_pkg: shared state type and default sizes for the Camera Link CC trigger path
package cl_ctrl_pkg;
  localparam int CL_CNT_W  = 24;
  localparam int CL_NUM_CC = 4;
  localparam int CL_TCNT_W = 16;
  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, HOLDOFF} cc_state_e;
endpackage

// File: rtl/cl_sync_edge.sv
// cl_sync_edge: two-flop synchronizer with a registered rising-edge pulse for async control inputs
module cl_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);
  logic [1:0] r_sync;
  logic       r_prev;
  logic       r_rise;
  // synchronize, compare against the previous synchronized level, register the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_async};
      r_prev <= r_sync[1];
      r_rise <= r_sync[1] & ~r_prev;
    end
  end
  assign o_rise = r_rise;
endmodule

// File: rtl/cl_cc_trigger_ctrl.sv
// cl_cc_trigger_ctrl: arbitrates sw/ext triggers and sequences delay, CC pulse and hold-off
module cl_cc_trigger_ctrl
  import cl_ctrl_pkg::*;
#(
  parameter int CNT_W  = CL_CNT_W,
  parameter int NUM_CC = CL_NUM_CC,
  parameter int TCNT_W = CL_TCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sw_trig,
  input  logic              ext_trig,
  input  logic [CNT_W-1:0]  delay_cyc,
  input  logic [CNT_W-1:0]  width_cyc,
  input  logic [CNT_W-1:0]  holdoff_cyc,
  input  logic [NUM_CC-1:0] cc_mask,
  input  logic [NUM_CC-1:0] cc_polarity,
  input  logic              overrun_clr,
  output logic [NUM_CC-1:0] cc_out,
  output logic              busy,
  output logic [TCNT_W-1:0] trig_count,
  output logic              overrun
);
  cc_state_e         r_state, w_state_n;
  logic [CNT_W-1:0]  r_cnt, w_cnt_n, r_width, r_holdoff, w_live_w1, w_lat_w1;
  logic [NUM_CC-1:0] r_mask, r_pol, r_cc, w_mask_n, w_pol_n;
  logic [TCNT_W-1:0] r_tcnt;
  logic              r_ovr, w_ext_req, w_req, w_accept;

  cl_sync_edge u_ext_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ext_trig),
    .o_rise  (w_ext_req)
  );

  assign w_req     = sw_trig | w_ext_req;
  assign w_accept  = w_req & enable & (r_state == IDLE);
  assign w_live_w1 = (width_cyc == '0) ? '0 : width_cyc - 1'b1;
  assign w_lat_w1  = (r_width == '0) ? '0 : r_width - 1'b1;

  // next state and counter: each phase loads value-1 and counts down to zero
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (!enable) begin
      w_state_n = IDLE;
      w_cnt_n   = '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_req) begin
          w_state_n = (delay_cyc != '0) ? DELAY : ACTIVE;
          w_cnt_n   = (delay_cyc != '0) ? delay_cyc - 1'b1 : w_live_w1;
        end
        DELAY: if (r_cnt == '0) begin
          w_state_n = ACTIVE;
          w_cnt_n   = w_lat_w1;
        end else w_cnt_n = r_cnt - 1'b1;
        ACTIVE: if (r_cnt == '0) begin
          w_state_n = (r_holdoff != '0) ? HOLDOFF : IDLE;
          w_cnt_n   = (r_holdoff != '0) ? r_holdoff - 1'b1 : '0;
        end else w_cnt_n = r_cnt - 1'b1;
        HOLDOFF: if (r_cnt == '0) w_state_n = IDLE;
          else w_cnt_n = r_cnt - 1'b1;
        default: w_state_n = IDLE;
      endcase
    end
  end

  // the registered line level follows the state being entered, so a zero delay pulses on the next cycle
  assign w_mask_n = w_accept ? cc_mask : r_mask;
  assign w_pol_n  = (w_accept || w_state_n == IDLE) ? cc_polarity : r_pol;

  // state register and phase counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // configuration latch, trigger count, sticky overrun and CC line register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_width   <= '0;
      r_holdoff <= '0;
      r_mask    <= '0;
      r_pol     <= '0;
      r_tcnt    <= '0;
      r_ovr     <= 1'b0;
      r_cc      <= '0;
    end else begin
      if (w_accept) begin
        r_width   <= width_cyc;
        r_holdoff <= holdoff_cyc;
        r_mask    <= cc_mask;
        r_pol     <= cc_polarity;
        r_tcnt    <= r_tcnt + 1'b1;
      end
      r_ovr <= (w_req & ~w_accept) | (r_ovr & ~overrun_clr);
      r_cc  <= ((w_state_n == ACTIVE) ? w_mask_n : '0) ^ w_pol_n;
    end
  end

  assign cc_out     = r_cc;
  assign busy       = (r_state != IDLE);
  assign trig_count = r_tcnt;
  assign overrun    = r_ovr;
endmodule

// File: tb/tb_cl_cc_trigger_ctrl.sv
// tb_cl_cc_trigger_ctrl: directed and random checks of the CC trigger sequencer against a timeline model
module tb_cl_cc_trigger_ctrl;
  localparam int TW = 10;
  logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, sw_trig = 1'b0, ext_trig = 1'b0, overrun_clr = 1'b0;
  logic [23:0]   delay_cyc = '0, width_cyc = '0, holdoff_cyc = '0;
  logic [3:0]    cc_mask = '0, cc_polarity = '0, cc_out;
  logic          busy, overrun;
  logic [TW-1:0] trig_count;
  int            errs = 0, checks = 0, first, nact, nb;
  logic [TW-1:0] c0;
  longint        cyc, idle_from, ps, pe;
  logic [4:0]    ext_hist;
  logic [TW-1:0] m_cnt;
  logic          m_ovr, exp_busy;
  logic [3:0]    ml_mask, ml_pol, exp_cc;

  always #5 clk = ~clk;

  cl_cc_trigger_ctrl #(.CNT_W(24), .NUM_CC(4), .TCNT_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sw_trig     (sw_trig),
    .ext_trig    (ext_trig),
    .delay_cyc   (delay_cyc),
    .width_cyc   (width_cyc),
    .holdoff_cyc (holdoff_cyc),
    .cc_mask     (cc_mask),
    .cc_polarity (cc_polarity),
    .overrun_clr (overrun_clr),
    .cc_out      (cc_out),
    .busy        (busy),
    .trig_count  (trig_count),
    .overrun     (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    cyc = 0; idle_from = 0; ps = 0; pe = 0;
    ext_hist = '0; m_cnt = '0; m_ovr = 1'b0; ml_mask = '0; ml_pol = '0;
  endtask

  // timeline model: an accepted trigger in cycle c pulses over [c+1+d, c+1+d+max(w,1)) and stays busy h more cycles
  task automatic model_edge();
    logic req, bsy;
    ext_hist = {ext_hist[3:0], ext_trig};
    req = sw_trig | (ext_hist[3] & ~ext_hist[4]);
    bsy = cyc < idle_from;
    if (!enable && bsy) idle_from = cyc + 1;
    if (req && (bsy || !enable)) m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
    if (req && !bsy && enable) begin
      m_cnt++;
      ml_mask = cc_mask;
      ml_pol = cc_polarity;
      ps = cyc + 1 + longint'(delay_cyc);
      pe = ps + ((width_cyc == 0) ? 1 : longint'(width_cyc));
      idle_from = pe + longint'(holdoff_cyc);
    end
    cyc++;
    exp_busy = cyc < idle_from;
    exp_cc = exp_busy ? (((cyc >= ps && cyc < pe) ? ml_mask : 4'b0) ^ ml_pol) : cc_polarity;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("cc_out", 32'(cc_out), 32'(exp_cc));
    check("busy", 32'(busy), 32'(exp_busy));
    check("trig_count", 32'(trig_count), 32'(m_cnt));
    check("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  initial begin
    cc_polarity = 4'b0101;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cc", 32'(cc_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(trig_count), 0);
    check("rst_ovr", 32'(overrun), 0);
    m_reset();
    rst_n = 1'b1;
    enable = 1'b1;
    tick();
    check("idle_pol", 32'(cc_out), 32'h5);

    delay_cyc = 3; width_cyc = 5; holdoff_cyc = 2; cc_mask = 4'b0011; cc_polarity = 4'b0000;
    tick();
    c0 = trig_count;
    sw_trig = 1'b1;
    first = 0; nact = 0; nb = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      sw_trig = 1'b0;
      if (cc_out == 4'b0011) begin nact++; if (first == 0) first = i; end
      if (!busy && nb == 0) nb = i;
    end
    check("basic_first", first, 4);
    check("basic_width", nact, 5);
    check("basic_idle", nb, 11);
    check("basic_count", 32'(trig_count), 32'(TW'(c0 + 1)));

    delay_cyc = 0; width_cyc = 0; holdoff_cyc = 0; cc_mask = 4'b1111;
    c0 = trig_count;
    sw_trig = 1'b1;
    tick();
    sw_trig = 1'b0;
    check("zero_pulse", 32'(cc_out), 32'hF);
    tick();
    check("zero_idle", 32'(busy), 0);
    tick();
    sw_trig = 1'b1;
    tick();
    sw_trig = 1'b0;
    check("zero_retrig", 32'(cc_out), 32'hF);
    check("zero_ovr", 32'(overrun), 0);
    check("zero_count", 32'(trig_count), 32'(TW'(c0 + 2)));
    repeat (2) tick();

    width_cyc = 4;
    c0 = trig_count;
    ext_trig = 1'b1;
    repeat (3) tick();
    sw_trig = 1'b1;
    tick();
    sw_trig = 1'b0;
    check("coll_count", 32'(trig_count), 32'(TW'(c0 + 1)));
    tick();
    sw_trig = 1'b1;
    tick();
    sw_trig = 1'b0;
    check("coll_ovr", 32'(overrun), 1);
    sw_trig = 1'b1; overrun_clr = 1'b1;
    tick();
    sw_trig = 1'b0;
    check("ovr_set_wins", 32'(overrun), 1);
    tick();
    overrun_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 0);
    repeat (6) tick();
    check("ext_hold_count", 32'(trig_count), 32'(TW'(c0 + 1)));
    check("ext_hold_busy", 32'(busy), 0);

    ext_trig = 1'b0;
    repeat (5) tick();
    width_cyc = 2;
    c0 = trig_count;
    ext_trig = 1'b1;
    first = 0; nact = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (cc_out == 4'b1111) begin nact++; if (first == 0) first = i; end
    end
    check("ext_first", first, 4);
    check("ext_width", nact, 2);
    check("ext_count", 32'(trig_count), 32'(TW'(c0 + 1)));

    ext_trig = 1'b0;
    delay_cyc = 10; width_cyc = 3; cc_polarity = 4'b1010;
    repeat (5) tick();
    sw_trig = 1'b1;
    tick();
    sw_trig = 1'b0;
    tick();
    check("abort_pre_busy", 32'(busy), 1);
    enable = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 0);
    check("abort_cc", 32'(cc_out), 32'hA);
    enable = 1'b1;
    tick();

    delay_cyc = 0; width_cyc = 6; cc_polarity = 4'b0000;
    sw_trig = 1'b1;
    tick();
    sw_trig = 1'b0;
    tick();
    check("pre_rst_pulse", 32'(cc_out), 32'hF);
    rst_n = 1'b0;
    #1;
    check("async_rst_cc", 32'(cc_out), 0);
    @(posedge clk);
    #1;
    m_reset();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 39) != 0);
      sw_trig = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) ext_trig = ~ext_trig;
      overrun_clr = ($urandom_range(0, 15) == 0);
      delay_cyc = 24'($urandom_range(0, 5));
      width_cyc = 24'($urandom_range(0, 4));
      holdoff_cyc = 24'($urandom_range(0, 3));
      cc_mask = 4'($urandom);
      if ($urandom_range(0, 3) == 0) cc_polarity = 4'($urandom);
      tick();
    end

    enable = 1'b1; sw_trig = 1'b0; ext_trig = 1'b0; overrun_clr = 1'b0;
    delay_cyc = 0; width_cyc = 0; holdoff_cyc = 0; cc_mask = 4'b1111;
    repeat (16) tick();
    for (int i = 0; i < 3000 && m_cnt != '1; i++) begin
      sw_trig = 1'b1;
      tick();
      sw_trig = 1'b0;
      tick();
    end
    check("wrap_preset", 32'(trig_count), 32'(TW'('1)));
    sw_trig = 1'b1;
    tick();
    sw_trig = 1'b0;
    check("wrap_zero", 32'(trig_count), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
